// File: rtl/mux_rr_arbiter_pkg.sv
// Shared encodings for the round-robin 2:1 mux arbiter: FSM states and select values.
package mux_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_rr_arbiter_mux2_w.sv
// Parameterised-width 2:1 mux; sel=0 picks a, sel=1 picks b.
module mux2_w #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  assign out = sel ? b : a;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 data mux between requesters A and B,
// with burst-limited tenure while the other side waits.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             sel,
  output logic             gnt_a,
  output logic             gnt_b
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_BURST - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             beat;
  logic             at_limit;
  logic             chg;

  assign gnt_a     = (state == ST_OWN_A);
  assign gnt_b     = (state == ST_OWN_B);
  assign out_valid = (gnt_a & req_a) | (gnt_b & req_b);
  assign beat      = out_valid & out_ready;
  // >= rather than == so a saturated counter still yields once the other side shows up
  assign at_limit  = beat & (cnt >= CNT_LIM);
  assign chg       = (state_nxt != state);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_a && req_b)  state_nxt = (last == SEL_B) ? ST_OWN_A : ST_OWN_B;
        else if (req_a)      state_nxt = ST_OWN_A;
        else if (req_b)      state_nxt = ST_OWN_B;
      end
      ST_OWN_A: begin
        if (!req_a)                state_nxt = req_b ? ST_OWN_B : ST_IDLE;
        else if (at_limit && req_b) state_nxt = ST_OWN_B;
      end
      ST_OWN_B: begin
        if (!req_b)                state_nxt = req_a ? ST_OWN_A : ST_IDLE;
        else if (at_limit && req_a) state_nxt = ST_OWN_A;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      last  <= SEL_B;
      sel   <= SEL_A;
    end else begin
      state <= state_nxt;
      if (chg) begin
        cnt <= '0;
        if (state == ST_OWN_A)          last <= SEL_A;
        else if (state == ST_OWN_B)     last <= SEL_B;
        // sel follows the new owner and holds through idle
        if (state_nxt == ST_OWN_A)      sel <= SEL_A;
        else if (state_nxt == ST_OWN_B) sel <= SEL_B;
      end else if (beat && (cnt != CNT_MAX)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  mux2_w #(.WIDTH(WIDTH)) u_mux (
    .a   (data_a),
    .b   (data_b),
    .sel (sel),
    .out (out_data)
  );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench: producers feed A/B queues, expected {sel,data} beats are
// queued in grant order and compared as the DUT delivers them.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0, out_ready = 1'b0;
  logic [7:0] data_a = 8'h00, data_b = 8'h00;
  logic       out_valid, sel, gnt_a, gnt_b;
  logic [7:0] out_data;

  int checks = 0, errs = 0;
  int cyc = 0, beats = 0, first_beat = -1, last_beat = -1;
  logic [7:0] qa[$], qb[$];
  logic [8:0] sb[$];
  bit acc_a, acc_b;

  mux_rr_arbiter #(.WIDTH(8), .MAX_BURST(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .data_a(data_a), .req_b(req_b), .data_b(data_b),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .sel(sel), .gnt_a(gnt_a), .gnt_b(gnt_b)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // producers: present head of queue, pop after an accepted beat
  initial begin
    #1;
    forever begin
      req_a  = (qa.size() > 0);
      data_a = (qa.size() > 0) ? qa[0] : 8'h00;
      @(posedge clk);
      acc_a = gnt_a & req_a & out_ready & !rst;
      #1;
      if (acc_a && qa.size() > 0) void'(qa.pop_front());
    end
  end

  initial begin
    #1;
    forever begin
      req_b  = (qb.size() > 0);
      data_b = (qb.size() > 0) ? qb[0] : 8'h00;
      @(posedge clk);
      acc_b = gnt_b & req_b & out_ready & !rst;
      #1;
      if (acc_b && qb.size() > 0) void'(qb.pop_front());
    end
  end

  // monitor: a beat seen at negedge is accepted on the following posedge
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("excl", 32'(gnt_a & gnt_b), 32'd0);
        if (gnt_a | gnt_b) chk("sel_own", 32'(sel), 32'(gnt_b));
        if (out_valid && out_ready) begin
          if (sb.size() == 0) chk("sb_unexp", 32'(sb.size()), 32'd1);
          else begin
            e = sb.pop_front();
            chk("beat", 32'({sel, out_data}), 32'(e));
          end
          beats++;
          if (first_beat < 0) first_beat = cyc;
          last_beat = cyc;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (sb.size() > 0 && n < maxc) begin @(negedge clk); #1; n++; end
    if (sb.size() > 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete(); qa.delete(); qb.delete();
    end
  endtask

  task automatic settle();
    repeat (3) tick();
  endtask

  task automatic wait_gnt(input bit b, input string tag);
    int n = 0;
    while (((b ? gnt_b : gnt_a) !== 1'b1) && n < 10) begin @(negedge clk); #1; n++; end
    chk(tag, 32'(b ? gnt_b : gnt_a), 32'd1);
  endtask

  initial begin
    out_ready = 1'b1;
    // reset with both requesting, then tie -> A, alternating 4-beat tenures
    for (int i = 0; i < 8; i++) begin
      qa.push_back(8'(8'h10 + i));
      qb.push_back(8'(8'h20 + i));
    end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) sb.push_back({1'b0, 8'(8'h10 + 4*r + i)});
      for (int i = 0; i < 4; i++) sb.push_back({1'b1, 8'(8'h20 + 4*r + i)});
    end
    repeat (3) begin
      @(negedge clk);
      chk("rst_gnt_a", 32'(gnt_a), 32'd0);
      chk("rst_gnt_b", 32'(gnt_b), 32'd0);
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
    end
    tick();
    rst = 1'b0; beats = 0; first_beat = -1;
    @(posedge clk); @(negedge clk);
    chk("tie_gnt_a", 32'(gnt_a), 32'd1);
    chk("tie_gnt_b", 32'(gnt_b), 32'd0);
    drain(40);
    settle();
    chk("rr_beats", 32'(beats), 32'd16);
    chk("rr_span", 32'(last_beat - first_beat), 32'd15);

    // single request, one-cycle arbitration latency
    qa.push_back(8'h5A); sb.push_back({1'b0, 8'h5A});
    @(negedge clk); @(negedge clk);
    chk("lat_req_a", 32'(req_a), 32'd1);
    chk("lat_gnt_a", 32'(gnt_a), 32'd0);
    @(negedge clk);
    chk("single_gnt_a", 32'(gnt_a), 32'd1);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", 32'(out_data), 32'h5A);
    chk("single_sel", 32'(sel), 32'd0);
    drain(20);
    settle();

    // stall: A owns, ready low for 5 cycles with B waiting; burst count must not move
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) qa.push_back(8'(8'h30 + i));
    wait_gnt(1'b0, "stall_gnt");
    tick();
    for (int i = 0; i < 2; i++) qb.push_back(8'(8'h40 + i));
    for (int i = 0; i < 4; i++) sb.push_back({1'b0, 8'(8'h30 + i)});
    for (int i = 0; i < 2; i++) sb.push_back({1'b1, 8'(8'h40 + i)});
    for (int i = 4; i < 6; i++) sb.push_back({1'b0, 8'(8'h30 + i)});
    repeat (5) begin
      @(negedge clk);
      chk("stall_gnt_a", 32'(gnt_a), 32'd1);
      chk("stall_gnt_b", 32'(gnt_b), 32'd0);
      chk("stall_sel", 32'(sel), 32'd0);
    end
    tick();
    beats = 0; first_beat = -1;
    out_ready = 1'b1;
    drain(30);
    settle();
    chk("stall_beats", 32'(beats), 32'd8);
    chk("stall_span", 32'(last_beat - first_beat), 32'd8);

    // release after 2 beats with B idle -> IDLE, sel held; then B alone
    qa.push_back(8'h61); qa.push_back(8'h62);
    sb.push_back({1'b0, 8'h61}); sb.push_back({1'b0, 8'h62});
    drain(20);
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rel_idle_a", 32'(gnt_a), 32'd0);
    chk("rel_idle_b", 32'(gnt_b), 32'd0);
    chk("rel_sel_hold", 32'(sel), 32'd0);
    tick();
    qb.push_back(8'hC3); sb.push_back({1'b1, 8'hC3});
    wait_gnt(1'b1, "rel_gnt_b");
    chk("rel_sel_b", 32'(sel), 32'd1);
    chk("rel_data_b", 32'(out_data), 32'hC3);
    drain(20);
    settle();

    // async reset mid-tenure with B owning and two beats taken
    for (int i = 0; i < 4; i++) qb.push_back(8'(8'h70 + i));
    sb.push_back({1'b1, 8'h70}); sb.push_back({1'b1, 8'h71});
    drain(20);
    tick();
    out_ready = 1'b0;
    chk("pre_gnt_b", 32'(gnt_b), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_gnt_b", 32'(gnt_b), 32'd0);
    chk("arst_gnt_a", 32'(gnt_a), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_sel", 32'(sel), 32'd0);
    qa.delete(); qb.delete();
    tick();
    qa.push_back(8'h81); qb.push_back(8'h91);
    sb.push_back({1'b0, 8'h81}); sb.push_back({1'b1, 8'h91});
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("post_tie_a", 32'(gnt_a), 32'd1);
    drain(20);
    settle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
